// File: rtl/mdu_hilo_unit.sv
// Sequential multiply/divide unit with HI/LO result registers.
// One iteration per cycle on operand magnitudes, then a sign-fix cycle writes hi/lo.
module mdu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [CW-1:0]        counter;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     orig_a;
  logic [2*WIDTH-1:0]   acc;

  logic                 signed_op;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_sh;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  // Magnitudes are taken only for signed ops; |-2^(W-1)| stays 2^(W-1) unsigned.
  always_comb begin
    signed_op = ~op[0];
    sign_a    = signed_op & a[WIDTH-1];
    sign_b    = signed_op & b[WIDTH-1];

    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = div_sh >= {1'b0, mag_b};
    div_diff = div_sh[WIDTH-1:0] - mag_b;
    div_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      orig_a      <= '0;
      acc         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op[1];
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
            mag_a   <= cond_neg(a, sign_a);
            mag_b   <= cond_neg(b, sign_b);
            orig_a  <= a;
            // Multiply seeds the low half with the multiplier, divide with the dividend.
            acc     <= {{WIDTH{1'b0}}, (op[1] ? cond_neg(a, sign_a) : cond_neg(b, sign_b))};
            counter <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        RUN: begin
          acc     <= is_div ? div_next : mul_next;
          counter <= counter + CW'(1);
          if (counter == LAST) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            {hi, lo}    <= cond_neg_wide(acc, neg_q);
            div_by_zero <= 1'b0;
          end else if (mag_b == '0) begin
            hi          <= orig_a;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi          <= cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
            lo          <= cond_neg(acc[WIDTH-1:0], neg_q);
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
